// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit framer.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Clocks per bit, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with occupancy count; a pop in the same cycle frees room for a push.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [7:0]               i_din,
  input  logic                     i_pop,
  output logic [7:0]               o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_drop    = i_push && !w_do_push;
  assign o_dout    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// Buffers crossbar bytes, appends CR/LF after each burst and shifts them out 8N1.
// Handshake: a byte is taken on every cycle tx_byte_valid=1; upstream starts a burst only while uart_ready=1.
module uart_tx_framer import uart_pkg::*; #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_MAX  = 8,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_byte_valid,
  output logic       uart_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       overflow,
  output tx_state_t  dbg_state
);

  localparam int DIV  = baud_div(CLK_HZ, BAUD);
  localparam int CW   = $clog2(DIV);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   BAUD_LAST     = CW'(DIV - 1);
  localparam logic [CNTW-1:0] READY_MAX_CNT = CNTW'(FIFO_DEPTH - BURST_MAX - 2);

  tx_state_t       r_state;
  tx_state_t       w_next_state;
  logic [CW-1:0]   r_baud;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_prev_valid;
  logic [1:0]      r_pending;
  logic            r_uart_ready;
  logic            r_overflow;

  logic            w_falling;
  logic [1:0]      w_pend_eff;
  logic            w_term_push;
  logic            w_push;
  logic [7:0]      w_din;
  logic            w_pop;
  logic [7:0]      w_dout;
  logic [CNTW-1:0] w_count;
  logic            w_empty;
  logic            w_drop;
  logic            w_wrap;

  // A falling edge restarts the terminator at CR, even over a still-pending LF.
  assign w_falling   = APPEND_CRLF && r_prev_valid && !tx_byte_valid;
  assign w_pend_eff  = w_falling ? 2'd2 : r_pending;
  assign w_term_push = !tx_byte_valid && (w_pend_eff != 2'd0);
  assign w_push      = tx_byte_valid || w_term_push;
  assign w_din       = tx_byte_valid ? tx_byte : ((w_pend_eff == 2'd2) ? ASCII_CR : ASCII_LF);
  assign w_wrap      = (r_baud == BAUD_LAST);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_valid <= 1'b0;
      r_pending    <= 2'd0;
      r_uart_ready <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_prev_valid <= tx_byte_valid;
      r_pending    <= w_term_push ? (w_pend_eff - 2'd1) : w_pend_eff;
      r_uart_ready <= (w_count <= READY_MAX_CNT) && (r_pending == 2'd0);
      r_overflow   <= r_overflow | w_drop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (!w_empty) w_next_state = START;
      START: if (w_wrap) w_next_state = DATA;
      DATA:  if (w_wrap && (r_bit_idx == 3'd7)) w_next_state = STOP;
      STOP:  if (w_wrap) w_next_state = w_empty ? IDLE : START;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    tx_serial = 1'b1;
    w_pop     = 1'b0;
    case (r_state)
      IDLE:  w_pop = !w_empty;
      START: tx_serial = 1'b0;
      DATA:  tx_serial = r_shift[0];
      STOP:  w_pop = w_wrap && !w_empty;
      default: tx_serial = 1'b1;
    endcase
    tx_busy = (r_state != IDLE) || !w_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      if (r_state == IDLE || w_wrap) r_baud <= '0;
      else                           r_baud <= r_baud + 1'b1;
      if (r_state != DATA) r_bit_idx <= 3'd0;
      else if (w_wrap)     r_bit_idx <= r_bit_idx + 3'd1;
      if (w_pop)                          r_shift <= w_dout;
      else if (r_state == DATA && w_wrap) r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  assign uart_ready = r_uart_ready;
  assign overflow   = r_overflow;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench: stimulus pushes expected bytes, a line monitor decodes frames and pops/compares.
module tb_uart_tx_framer;
  import uart_pkg::*;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_byte_valid = 1'b0;
  logic       uart_ready;
  logic       tx_serial;
  logic       tx_busy;
  logic       overflow;
  tx_state_t  dbg_state;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  bit         mon_busy = 1'b0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_tx_framer #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(16), .BURST_MAX(8), .APPEND_CRLF(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .tx_byte(tx_byte), .tx_byte_valid(tx_byte_valid),
    .uart_ready(uart_ready), .tx_serial(tx_serial), .tx_busy(tx_busy),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic [7:0] b);
    @(posedge clk);
    #1;
    tx_byte_valid = v;
    tx_byte       = b;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_err++;
      $display("FAIL %s_timeout: %0d frames still expected after %0d cycles", name, exp_q.size(), n);
    end
    repeat (20) @(negedge clk);
  endtask

  // Scoreboard monitor
  task automatic mon_wait(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  initial begin : monitor
    bit         ab;
    logic [7:0] got;
    int         t0;
    forever begin
      @(negedge clk);
      if (!rst && tx_serial === 1'b0) begin
        ab = 1'b0;
        t0 = cyc;
        got = 8'h00;
        mon_busy = 1'b1;
        mon_wait(DIV / 2, ab);
        if (!ab) check("start_bit", tx_serial, 1'b0);
        for (int i = 0; i < 8; i++) begin
          mon_wait(DIV, ab);
          got[i] = tx_serial;
        end
        mon_wait(DIV, ab);
        if (!ab) begin
          check("stop_bit", tx_serial, 1'b1);
          start_q.push_back(t0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame: got %02h, required no frame (cycle %0d)", got, cyc);
          end else begin
            check("frame_byte", got, exp_q.pop_front());
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : stimulus
    int t0;
    logic [7:0] burst [6];
    burst = '{8'h32, 8'h35, 8'h30, 8'h34, 8'h33, 8'h31};

    // 1: reset idle
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_ready", uart_ready, 1'b0);
    check("rst_serial", tx_serial, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_before_edge", uart_ready, 1'b0);
    @(negedge clk);
    check("ready_after_release", uart_ready, 1'b1);
    check("idle_serial", tx_serial, 1'b1);
    check("idle_overflow", overflow, 1'b0);
    check("idle_busy", tx_busy, 1'b0);
    check("idle_state", dbg_state, IDLE);

    // 2+3: six-byte burst, back-to-back frames, ready headroom
    start_q.delete();
    foreach (burst[i]) exp_q.push_back(burst[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    drive(1'b1, burst[0]);
    t0 = cyc;
    for (int i = 1; i < 6; i++) drive(1'b1, burst[i]);
    drive(1'b0, 8'h00);
    wait_cyc(t0 + 20);
    check("t3_ready_low_early", uart_ready, 1'b0);
    wait_cyc(t0 + 60);
    check("t3_ready_low_mid", uart_ready, 1'b0);
    wait_cyc(t0 + 110);
    check("t3_ready_back", uart_ready, 1'b1);
    wait_drain("t2", 1500);
    check("t2_frame_count", start_q.size(), 8);
    if (start_q.size() > 0) check("t2_first_start", start_q[0] - t0, 2);
    for (int i = 1; i < start_q.size(); i++)
      check("t2_frame_gap", start_q[i] - start_q[i-1], 10 * DIV);

    // 4: overflow with 20 consecutive 'A'
    check("t4_no_overflow_yet", overflow, 1'b0);
    repeat (17) exp_q.push_back(8'h41);
    for (int i = 0; i < 20; i++) drive(1'b1, 8'h41);
    drive(1'b0, 8'h00);
    @(negedge clk);
    check("t4_overflow", overflow, 1'b1);
    wait_drain("t4", 2600);
    repeat (300) @(negedge clk);
    check("t4_idle_after", tx_busy, 1'b0);
    check("t4_overflow_sticky", overflow, 1'b1);

    do_reset();
    @(negedge clk);
    check("reset_clears_overflow", overflow, 1'b0);

    // 5: reset mid-frame during bit 3 of 0x55
    drive(1'b1, 8'h55);
    t0 = cyc;
    drive(1'b0, 8'h00);
    wait_cyc(t0 + 45);
    check("t5_bit3_low", tx_serial, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t5_async_serial", tx_serial, 1'b1);
    check("t5_async_busy", tx_busy, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (300) @(negedge clk);
    check("t5_quiet_busy", tx_busy, 1'b0);
    check("t5_quiet_serial", tx_serial, 1'b1);

    // 6: valid during pending terminator
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    drive(1'b1, 8'h44);
    drive(1'b0, 8'h00);
    drive(1'b1, 8'h45);
    drive(1'b0, 8'h00);
    wait_drain("t6", 1000);
    repeat (200) @(negedge clk);
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_no_overflow", overflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
